// File: rtl/intc_arbiter.sv
// intc_arbiter: edge-latching interrupt controller with a four-word register slave.
// Define INTC_ROTATE_PRIORITY_EN for round-robin arbitration (fixed otherwise).
module intc_arbiter #(
  parameter int          NSRC = 8,
  parameter logic [11:0] BASE = 12'hFF0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_src,
  input  logic [11:0]     address,
  input  logic [15:0]     wdata,
  input  logic            memwt,
  input  logic            intack,
  output logic            INT,
  output logic [15:0]     rdata,
  output logic            rd_sel
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [NSRC-1:0] r_sync1;
  logic [NSRC-1:0] r_sync2;
  logic [NSRC-1:0] r_prev;
  logic [NSRC-1:0] r_mask;
  logic [NSRC-1:0] r_pend;
  logic [2:0]      r_id;
  logic            r_int;

  logic [NSRC-1:0] w_edge;
  logic [NSRC-1:0] w_req;
  logic [NSRC-1:0] w_onehot;
  logic [NSRC-1:0] w_clr;
  logic [NSRC-1:0] w_pend_nxt;
  logic [2:0]      w_win;
  logic [15:0]     w_reg;
  logic            w_hit;
  logic            w_wr_mask;
  logic            w_wr_pend;
  logic            w_wr_eoi;
  logic            w_ack;
  logic            w_any;
  logic            w_latch;
  logic            w_unused;

  assign w_unused = &{1'b0, wdata};

  assign w_hit     = (address[11:2] == BASE[11:2]);
  assign w_wr_mask = memwt & w_hit & (address[1:0] == 2'd0);
  assign w_wr_pend = memwt & w_hit & (address[1:0] == 2'd1);
  assign w_wr_eoi  = memwt & w_hit & (address[1:0] == 2'd2);

  assign w_edge  = r_sync2 & ~r_prev;
  assign w_req   = r_pend & r_mask;
  assign w_any   = |w_req;
  assign w_ack   = (r_state == REQ) & intack;
  assign w_latch = (r_state == IDLE) & w_any;

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_onehot[i] = (r_id == 3'(i));
    end
  end

  // A fresh edge always beats a same-cycle W1C or acknowledge clear.
  assign w_clr = (w_wr_pend ? wdata[NSRC-1:0] : '0)
               | (w_ack ? w_onehot : '0);
  assign w_pend_nxt = (r_pend & ~w_clr) | w_edge;

`ifdef INTC_ROTATE_PRIORITY_EN
  logic [2:0] r_ptr;

  always_comb begin
    int j;
    j = 0;
    w_win = '0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      j = (int'(r_ptr) + k) % NSRC;
      if (w_req[j]) w_win = 3'(j);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_ack) begin
      r_ptr <= (r_id == 3'(NSRC - 1)) ? 3'd0 : r_id + 3'd1;
    end
  end
`else
  always_comb begin
    w_win = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_req[i]) w_win = 3'(i);
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_any)    w_state_nxt = REQ;
      REQ:     if (intack)   w_state_nxt = SERVICE;
      SERVICE: if (w_wr_eoi) w_state_nxt = IDLE;
      default:               w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_mask  <= '0;
      r_pend  <= '0;
      r_id    <= '0;
      r_int   <= 1'b0;
      r_state <= IDLE;
    end else begin
      r_sync1 <= irq_src;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_pend  <= w_pend_nxt;
      r_state <= w_state_nxt;
      r_int   <= (w_state_nxt == REQ);
      if (w_wr_mask) r_mask <= wdata[NSRC-1:0];
      if (w_latch)   r_id   <= w_win;
    end
  end

  always_comb begin
    w_reg = '0;
    unique case (address[1:0])
      2'd0:    w_reg[NSRC-1:0] = r_mask;
      2'd1:    w_reg[NSRC-1:0] = r_pend;
      2'd2:    w_reg = '0;
      default: w_reg = {r_int, (r_state == SERVICE), 11'd0, r_id};
    endcase
  end

  assign rdata  = intack ? {13'd0, r_id} : (w_hit ? w_reg : 16'd0);
  assign rd_sel = intack | w_hit;
  assign INT    = r_int;

endmodule

// File: tb/tb_intc_arbiter.sv
// tb_intc_arbiter: vector table, directed corner sequences and randomized
// traffic checked against a cycle-level behavioural model.
module tb_intc_arbiter;

  localparam logic [11:0] BASE   = 12'hFF0;
  localparam logic [11:0] A_MASK = BASE;
  localparam logic [11:0] A_PEND = BASE + 12'd1;
  localparam logic [11:0] A_EOI  = BASE + 12'd2;
  localparam logic [11:0] A_STAT = BASE + 12'd3;
  localparam int S_IDLE = 0;
  localparam int S_REQ  = 1;
  localparam int S_SVC  = 2;

  logic        clk;
  logic        rst;
  logic [7:0]  irq_src;
  logic [11:0] address;
  logic [15:0] wdata;
  logic        memwt;
  logic        intack;
  logic        INT;
  logic [15:0] rdata;
  logic        rd_sel;

  intc_arbiter #(.NSRC(8), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src),
    .address(address), .wdata(wdata), .memwt(memwt),
    .intack(intack), .INT(INT), .rdata(rdata), .rd_sel(rd_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // behavioural model
  logic [7:0] hist [0:4095];
  int         t;
  int         m_state;
  int         m_id;
  int         m_rr;
  logic [7:0] m_mask;
  logic [7:0] m_pend;
  bit         m_en;

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
    end
  endtask

  function automatic int pick(logic [7:0] r, int start);
    for (int k = 0; k < 8; k++) begin
      if (r[(start + k) % 8]) return (start + k) % 8;
    end
    return 0;
  endfunction

  function automatic logic [15:0] m_rdata();
    logic [15:0] v;
    v = 16'd0;
    if (intack) return 16'(m_id);
    if (address >= BASE && address <= BASE + 12'd3) begin
      case (int'(address - BASE))
        0: v = {8'd0, m_mask};
        1: v = {8'd0, m_pend};
        2: v = 16'd0;
        default: v = {(m_state == S_REQ), (m_state == S_SVC),
                      11'd0, 3'(m_id)};
      endcase
    end
    return v;
  endfunction

  task automatic mupdate();
    logic [7:0] ev;
    logic [7:0] clr;
    logic [7:0] req;
    int start;
    t++;
    hist[t] = irq_src;
    if (rst) begin
      hist[t] = 0; hist[t-1] = 0; hist[t-2] = 0;
      m_state = S_IDLE; m_id = 0; m_rr = 0;
      m_mask = 0; m_pend = 0;
      return;
    end
    // event = line seen high at t-2 after being low at t-3
    ev = hist[t-2] & ~hist[t-3];
    clr = 8'd0;
    if (memwt && address == A_PEND) clr = wdata[7:0];
    if (m_state == S_REQ && intack) clr[m_id] = 1'b1;
    req = m_pend & m_mask;
`ifdef INTC_ROTATE_PRIORITY_EN
    start = m_rr;
`else
    start = 0;
`endif
    case (m_state)
      S_IDLE: if (req != 0) begin
        m_id = pick(req, start);
        m_state = S_REQ;
      end
      S_REQ: if (intack) begin
        m_state = S_SVC;
        m_rr = (m_id + 1) % 8;
      end
      default: if (memwt && address == A_EOI) m_state = S_IDLE;
    endcase
    m_pend = (m_pend & ~clr) | ev;
    if (memwt && address == A_MASK) m_mask = wdata[7:0];
  endtask

  task automatic half();
    @(negedge clk);
    if (m_en) begin
      chk("mdl_INT", 16'(INT), 16'(m_state == S_REQ));
      chk("mdl_rdata", rdata, m_rdata());
      chk("mdl_rd_sel", 16'(rd_sel),
          16'(intack || (address >= BASE && address <= BASE + 12'd3)));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    mupdate();
    #1;
  endtask

  task automatic clr_bus();
    address = 12'd0; wdata = 16'd0; memwt = 1'b0; intack = 1'b0;
  endtask

  task automatic idle(int n);
    clr_bus();
    repeat (n) begin half(); tick(); end
  endtask

  task automatic pulse(logic [7:0] m);
    irq_src = m; half(); tick(); irq_src = 8'd0;
  endtask

  task automatic wr(logic [11:0] a, logic [15:0] d);
    address = a; wdata = d; memwt = 1'b1;
    half(); tick(); clr_bus();
  endtask

  task automatic rd(logic [11:0] a, logic [15:0] e, string nm);
    address = a;
    half(); chk(nm, rdata, e); chk({nm, "_sel"}, 16'(rd_sel), 16'd1);
    tick(); clr_bus();
  endtask

  task automatic wait_int(string nm);
    bit got;
    got = 1'b0;
    clr_bus();
    for (int i = 0; i < 12 && !got; i++) begin
      half(); if (INT) got = 1'b1; tick();
    end
    chk(nm, 16'(got), 16'd1);
  endtask

  task automatic ack(logic [15:0] e, string nm);
    clr_bus(); intack = 1'b1;
    half(); chk(nm, rdata, e); chk({nm, "_sel"}, 16'(rd_sel), 16'd1);
    tick(); intack = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) begin
      idle(3);
      if (m_state == S_REQ) begin
        intack = 1'b1; half(); tick(); intack = 1'b0;
        wr(A_EOI, 16'd0);
      end else if (m_state == S_SVC) begin
        wr(A_EOI, 16'd0);
      end
    end
  endtask

  typedef struct {
    logic [7:0]  irq;
    logic [11:0] addr;
    logic        we;
    logic [15:0] wd;
    logic        ak;
    logic        e_int;
    logic [15:0] e_rd;
    logic        e_sel;
  } vec_t;

  vec_t tv [$];

  function automatic vec_t mk(logic [7:0] irq, logic [11:0] a, logic we,
                              logic [15:0] wd, logic ak, logic ei,
                              logic [15:0] er, logic es);
    vec_t v;
    v.irq = irq; v.addr = a; v.we = we; v.wd = wd; v.ak = ak;
    v.e_int = ei; v.e_rd = er; v.e_sel = es;
    return v;
  endfunction

  int exp_vec [3];
  int r;

  initial begin
    for (int i = 0; i < 4096; i++) hist[i] = 8'd0;
    t = 3; m_en = 1'b0;
    m_state = S_IDLE; m_id = 0; m_rr = 0; m_mask = 0; m_pend = 0;
    irq_src = 8'd0; clr_bus(); rst = 1'b1;
    half(); tick(); half(); tick();
    rst = 1'b0; m_en = 1'b1;

    // one row per cycle: inputs, then outputs seen before the edge
    tv.push_back(mk(8'h00, A_STAT, 0, 16'h0000, 0, 0, 16'h0000, 1));
    tv.push_back(mk(8'h00, A_MASK, 1, 16'h00FF, 0, 0, 16'h0000, 1));
    tv.push_back(mk(8'h08, A_MASK, 0, 16'h0000, 0, 0, 16'h00FF, 1));
    tv.push_back(mk(8'h00, 12'h000, 0, 16'h0000, 0, 0, 16'h0000, 0));
    tv.push_back(mk(8'h00, 12'h100, 0, 16'h0000, 0, 0, 16'h0000, 0));
    tv.push_back(mk(8'h00, A_PEND, 0, 16'h0000, 0, 0, 16'h0008, 1));
    tv.push_back(mk(8'h00, 12'h000, 0, 16'h0000, 0, 1, 16'h0000, 0));
    tv.push_back(mk(8'h00, 12'h000, 0, 16'h0000, 1, 1, 16'h0003, 1));
    tv.push_back(mk(8'h00, A_PEND, 0, 16'h0000, 0, 0, 16'h0000, 1));
    tv.push_back(mk(8'h00, A_STAT, 0, 16'h0000, 0, 0, 16'h4003, 1));
    tv.push_back(mk(8'h00, A_EOI, 1, 16'hFFFF, 0, 0, 16'h0000, 1));
    tv.push_back(mk(8'h00, A_STAT, 0, 16'h0000, 0, 0, 16'h0003, 1));
    tv.push_back(mk(8'h00, 12'h000, 0, 16'h0000, 1, 0, 16'h0003, 1));
    tv.push_back(mk(8'h00, A_STAT, 1, 16'hFFFF, 0, 0, 16'h0003, 1));
    tv.push_back(mk(8'h00, A_STAT, 0, 16'h0000, 0, 0, 16'h0003, 1));

    foreach (tv[i]) begin
      irq_src = tv[i].irq; address = tv[i].addr; memwt = tv[i].we;
      wdata = tv[i].wd; intack = tv[i].ak;
      half();
      chk($sformatf("vec%0d_INT", i), 16'(INT), 16'(tv[i].e_int));
      chk($sformatf("vec%0d_rdata", i), rdata, tv[i].e_rd);
      chk($sformatf("vec%0d_rd_sel", i), 16'(rd_sel), 16'(tv[i].e_sel));
      tick();
    end
    irq_src = 8'd0; clr_bus();

    // simultaneous 2 and 5, re-fired while in service
`ifdef INTC_ROTATE_PRIORITY_EN
    exp_vec = '{2, 5, 2};
`else
    exp_vec = '{2, 2, 2};
`endif
    for (int k = 0; k < 3; k++) begin
      pulse(8'h24); idle(4);
      if (k > 0) wr(A_EOI, 16'd0);
      wait_int($sformatf("pair%0d_int", k));
      ack(16'(exp_vec[k]), $sformatf("pair%0d_vec", k));
    end
    drain();

    // back-to-back service: INT one cycle after EOI
    pulse(8'h24); idle(4); wait_int("b2b_int");
    ack(16'h0002, "b2b_vec2");
    wr(A_EOI, 16'd0);
    half(); chk("b2b_idle_gap", 16'(INT), 16'd0); tick();
    half(); chk("b2b_int_back", 16'(INT), 16'd1); tick();
    ack(16'h0005, "b2b_vec5");
    wr(A_EOI, 16'd0);
    drain();

    // masked source, late unmask, and W1C before arbitration
    wr(A_MASK, 16'h0000);
    pulse(8'h02); idle(4);
    rd(A_PEND, 16'h0002, "masked_pend");
    half(); chk("masked_no_int", 16'(INT), 16'd0); tick();
    wr(A_MASK, 16'h0002);
    wait_int("unmask_int");
    ack(16'h0001, "unmask_vec");
    wr(A_EOI, 16'd0);
    wr(A_MASK, 16'h0000);
    pulse(8'h02); idle(4);
    wr(A_PEND, 16'h0002);
    wr(A_MASK, 16'h0002);
    idle(4);
    half(); chk("w1c_no_int", 16'(INT), 16'd0); tick();
    rd(A_PEND, 16'h0000, "w1c_pend");

    // same source re-fires while in service
    wr(A_MASK, 16'h00FF);
    pulse(8'h10); wait_int("svc4_int");
    ack(16'h0004, "svc4_vec");
    pulse(8'h10); idle(4);
    rd(A_STAT, 16'h4004, "svc4_status");
    rd(A_PEND, 16'h0010, "svc4_pend");
    wr(A_EOI, 16'd0);
    wait_int("svc4_reint");
    ack(16'h0004, "svc4_revec");
    wr(A_EOI, 16'd0);

    // reset while requesting
    pulse(8'h01); wait_int("rst_req_int");
    rst = 1'b1; half(); tick(); rst = 1'b0;
    half(); chk("rst_int", 16'(INT), 16'd0); tick();
    rd(A_PEND, 16'h0000, "rst_pend");
    rd(A_MASK, 16'h0000, "rst_mask");
    rd(A_STAT, 16'h0000, "rst_status");

    // set beats same-cycle W1C on bit 6
    pulse(8'h40); idle(4);
    rd(A_PEND, 16'h0040, "b6_pend");
    irq_src = 8'h40; half(); tick();
    irq_src = 8'h00; half(); tick();
    address = A_PEND; wdata = 16'h0040; memwt = 1'b1;
    half(); tick(); clr_bus();
    rd(A_PEND, 16'h0040, "b6_set_wins");
    wr(A_PEND, 16'h0040);
    rd(A_PEND, 16'h0000, "b6_cleared");

    // randomized traffic against the model
    wr(A_MASK, 16'h00FF);
    for (int c = 0; c < 2500; c++) begin
      clr_bus();
      irq_src = irq_src ^ 8'($urandom & $urandom & $urandom);
      r = $urandom_range(0, 99);
      if (r < 6) begin
        address = A_MASK; wdata = 16'($urandom); memwt = 1'b1;
      end else if (r < 14) begin
        address = A_PEND; wdata = 16'($urandom); memwt = 1'b1;
      end else if (r < 26) begin
        address = A_EOI; wdata = 16'($urandom); memwt = 1'b1;
      end else if (r < 36) begin
        address = BASE + 12'($urandom_range(0, 3));
      end else if (r < 40) begin
        address = 12'($urandom_range(0, 12'hFEF));
        wdata = 16'($urandom); memwt = 1'($urandom);
      end
      if ((m_state == S_REQ && $urandom_range(0, 2) == 0) ||
          $urandom_range(0, 49) == 0) intack = 1'b1;
      rst = ($urandom_range(0, 299) == 0);
      half(); tick();
      rst = 1'b0;
      if (m_mask == 0 && $urandom_range(0, 9) == 0) begin
        clr_bus(); address = A_MASK; wdata = 16'h00FF; memwt = 1'b1;
        half(); tick();
      end
    end
    clr_bus();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
